// File: rtl/dual_cache_mem_controller.sv
// rtl/dual_cache_mem_controller.sv - two-channel prefetch feeder streaming generated words into FWFT FIFOs
// Each channel walks its source address space once per reset and keeps its FIFO topped up.

module dcmc_channel #(
  parameter int         CACHE_WIDTH = 162,
  parameter int         NUM_WORDS   = 64,
  parameter int         FIFO_DEPTH  = 4,
  parameter logic [1:0] CH_ID       = 2'b00
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clk_en,
  input  logic                   read_req,
  output logic [CACHE_WIDTH-1:0] cache_out,
  output logic                   empty
);

  localparam int              PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int              CW      = $clog2(FIFO_DEPTH + 1);
  localparam int              REPS    = CACHE_WIDTH / 18;
  localparam logic [16:0]     END_FA  = 17'(NUM_WORDS);
  localparam logic [CW-1:0]   DEPTH   = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0]   PTR_MAX = PW'(FIFO_DEPTH - 1);

  logic [CACHE_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [CW-1:0]          count;
  logic [16:0]            fa;
  logic                   push;
  logic                   pop;
  logic [CACHE_WIDTH-1:0] src_word;

  // Source memory is implied: every word is its 18-bit tag repeated across the width.
  assign src_word = {REPS{{CH_ID, fa[15:0]}}};

  // Push decision uses the pre-pop count, so a full FIFO being read does not refill this edge.
  assign push  = (fa < END_FA) && (count < DEPTH);
  assign pop   = read_req && (count != '0);
  assign empty = (count == '0);
  assign cache_out = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fa     <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clk_en) begin
      if (push) begin
        mem[wr_ptr] <= src_word;
        wr_ptr      <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + 1'b1;
        fa          <= fa + 17'd1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

module dual_cache_mem_controller #(
  parameter int CACHE_WIDTH = 162,
  parameter int NUM_WORDS   = 64,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clk_en,
  input  logic                   read_req02,
  input  logic                   read_req13,
  output logic [CACHE_WIDTH-1:0] cache_out02,
  output logic [CACHE_WIDTH-1:0] cache_out13,
  output logic                   empty02,
  output logic                   empty13
);

  dcmc_channel #(
    .CACHE_WIDTH(CACHE_WIDTH),
    .NUM_WORDS  (NUM_WORDS),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CH_ID      (2'b00)
  ) u_ch02 (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_en   (clk_en),
    .read_req (read_req02),
    .cache_out(cache_out02),
    .empty    (empty02)
  );

  dcmc_channel #(
    .CACHE_WIDTH(CACHE_WIDTH),
    .NUM_WORDS  (NUM_WORDS),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CH_ID      (2'b01)
  ) u_ch13 (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_en   (clk_en),
    .read_req (read_req13),
    .cache_out(cache_out13),
    .empty    (empty13)
  );

endmodule

// File: tb/tb_dual_cache_mem_controller.sv
// tb/tb_dual_cache_mem_controller.sv - randomized bench against an address-counting reference model
// The model tracks only words fetched and words popped per channel; FIFO contents follow from those.

module tb_dual_cache_mem_controller;

  localparam int CW = 162;
  localparam int NW = 64;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clk_en = 1'b1;
  logic          read_req02 = 1'b0;
  logic          read_req13 = 1'b0;
  logic [CW-1:0] cache_out02;
  logic [CW-1:0] cache_out13;
  logic          empty02;
  logic          empty13;

  int n_checks = 0;
  int n_fail   = 0;
  int fetched [2];
  int popped  [2];

  dual_cache_mem_controller #(
    .CACHE_WIDTH(CW),
    .NUM_WORDS  (NW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_en     (clk_en),
    .read_req02 (read_req02),
    .read_req13 (read_req13),
    .cache_out02(cache_out02),
    .cache_out13(cache_out13),
    .empty02    (empty02),
    .empty13    (empty13)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] word_of(input int ch, input int addr);
    logic [17:0] e;
    logic [1:0]  id;
    logic [15:0] a;
    id = ch[1:0];
    a  = addr[15:0];
    e  = {id, a};
    return {(CW / 18){e}};
  endfunction

  function automatic logic [CW-1:0] exp_out(input int ch);
    return (fetched[ch] == popped[ch]) ? '0 : word_of(ch, popped[ch]);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      fetched[c] = 0;
      popped[c]  = 0;
    end
  endtask

  task automatic model_edge(input logic r02, input logic r13);
    logic req [2];
    int   held;
    req[0] = r02;
    req[1] = r13;
    for (int c = 0; c < 2; c++) begin
      held = fetched[c] - popped[c];
      if (req[c] && held > 0) popped[c]++;
      if (fetched[c] < NW && held < FD) fetched[c]++;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_empty02"}, CW'(empty02), CW'(fetched[0] == popped[0]));
    check({tag, "_empty13"}, CW'(empty13), CW'(fetched[1] == popped[1]));
    check({tag, "_out02"}, cache_out02, exp_out(0));
    check({tag, "_out13"}, cache_out13, exp_out(1));
  endtask

  // Inputs change just after the falling edge; the model steps with what the rising edge saw.
  task automatic cycle(input string tag, input logic en, input logic r02, input logic r13);
    clk_en     = en;
    read_req02 = r02;
    read_req13 = r13;
    @(posedge clk);
    if (en) model_edge(r02, r13);
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all({tag, "_async"});
    @(posedge clk);
    @(negedge clk);
    compare_all({tag, "_held"});
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    compare_all("por");
    @(negedge clk);
    rst_n = 1'b1;

    cycle("first_push", 1'b1, 1'b1, 1'b0);
    check("first_word02", cache_out02, {9{18'h00000}});
    check("first_word13", cache_out13, {9{18'h10000}});
    for (int i = 0; i < 6; i++) cycle("fill", 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 70; i++) cycle("stream02", 1'b1, 1'b1, 1'b0);
    check("exhaust_popped02", CW'(popped[0]), CW'(NW));
    for (int i = 0; i < 5; i++) cycle("drained_req02", 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 140; i++) cycle("alt13", 1'b1, 1'b0, (i % 2) == 0);

    pulse_reset("rst_mid");
    for (int i = 0; i < 8; i++) cycle("refill", 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cycle("freeze", 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) cycle("resume", 1'b1, 1'b1, 1'b1);

    for (int round = 0; round < 3; round++) begin
      pulse_reset("rst_rand");
      for (int i = 0; i < 250; i++) begin
        if ($urandom_range(0, 199) == 0) begin
          pulse_reset("rst_rand_mid");
        end
        cycle("rand", $urandom_range(0, 9) < 8, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
      end
      for (int i = 0; i < 150; i++) cycle("rand_drain", 1'b1, 1'b1, 1'b1);
      check("rand_empty02_end", CW'(empty02), CW'(1));
      check("rand_empty13_end", CW'(empty13), CW'(1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dual_cache_mem_controller.md
# dual_cache_mem_controller

Dual-channel on-chip cache feeder for the CNN datapath. It autonomously streams fixed-content words from two internal source memories into two independent prefetch FIFOs: channel 02 and channel 13. Downstream consumers pop one CACHE_WIDTH-bit word per request. Each channel exposes first-word-fall-through data and an empty flag.

## Interface
Parameters:
- CACHE_WIDTH, 162, word width of each cache output; must be a multiple of 18.
- NUM_WORDS, 64, words held in each channel's source memory, max 65536.
- FIFO_DEPTH, 4, prefetch FIFO entries per channel; power of two.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clk_en  in  1  global enable; when 0, all state (addresses, FIFOs, outputs) holds.
- read_req02  in  1  pop request, channel 02.
- read_req13  in  1  pop request, channel 13.
- cache_out02  out  CACHE_WIDTH  head word of channel 02 FIFO.
- cache_out13  out  CACHE_WIDTH  head word of channel 13 FIFO.
- empty02  out  1  channel 02 FIFO holds no word.
- empty13  out  1  channel 13 FIFO holds no word.

## Operation
- Two identical, fully independent channels; ch02 uses id 2'b00, ch13 uses id 2'b01.
- Source word at address a is 9 (CACHE_WIDTH/18) copies of the 18-bit value {id[1:0], a[15:0]}. It is generated by logic or ROM, and no write port exists.
- Per channel state:
  - fetch address fa, reset 0.
  - FIFO storage, all entries reset 0.
  - write pointer, read pointer and count, all reset 0.
- Push: on a clk_en edge with fa < NUM_WORDS and count < FIFO_DEPTH (count before any pop that cycle), write word(fa) at the write pointer and increment fa.
- Pop: on a clk_en edge with read_req=1 and empty=0, advance the read pointer.
- Simultaneous push and pop: count unchanged, both pointers advance.
- read_req while empty=1 is ignored, with no underflow and no state change.
- Exhaustion: once fa == NUM_WORDS, pushing stops permanently until reset. The FIFO drains, and empty then stays 1.
- Output behaviour:
  - empty = (count == 0).
  - cache_out = storage[read pointer] when empty=0, else all zeros.
- Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset (asynchronous assert): empty02 = empty13 = 1, cache_out02 = cache_out13 = 0, all counters 0. Reset may assert mid-stream and discards all contents.
- Fill after reset:
  - First clk_en edge after rst_n rises pushes word 0, so empty falls 1 cycle after the release edge.
  - FIFO reaches full after FIFO_DEPTH enabled edges with no reads.
- Read latency: the popped word is visible on cache_out while read_req is sampled. After the edge, the next word appears in the same cycle that empty updates.
- Sustained read_req=1: one word per cycle, with empty never reasserting until the source is exhausted.
- Last word: after word NUM_WORDS-1 is popped, empty=1 on the following cycle and stays 1.
- clk_en=0: no push and no pop; outputs hold; read_req is ignored.

## Test plan
- Reset with no requests, clk_en=1 → within 1 cycle of release empty02 = empty13 = 0.
  - cache_out02 = 9×18'h00000; cache_out13 = 9×{2'b01,16'h0000}.
  - Counts saturate at 4.
- Continuous read_req02=1 for 64 cycles → cache_out02 steps through addresses 0..63, one per cycle, in order.
  - empty02 rises after the 64th pop; channel 13 is unaffected.
- Alternating read_req13 1/0 → words are delivered in address order with no skips or duplicates.
- read_req02=1 while empty02=1 (right after reset, or after exhaustion) → no state change; cache_out02 stays 0.
- clk_en=0 for 5 cycles mid-stream with read_req=1 → outputs and the address sequence freeze. Streaming resumes from the same word when clk_en returns.
- rst_n pulsed low mid-stream → empty goes to 1 and cache_out to 0 immediately, and streaming restarts at address 0.
